// File: rtl/result_reader_pkg.sv
// rtl/result_reader_pkg.sv - shared types and constants for the result SRAM reader
package result_reader_pkg;

    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_CNT_W  = 13;

    localparam int FIFO_DEPTH = 2;
    localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/result_reader_fifo.sv
// rtl/result_reader_fifo.sv - small synchronous FIFO holding returned SRAM words
module result_reader_fifo
    import result_reader_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_W-1:0]     push_data,
    input  logic                  pop,
    output logic [DATA_W-1:0]     head,
    output logic                  full,
    output logic                  empty,
    output logic [FIFO_CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == FIFO_CNT_W'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + FIFO_CNT_W'(do_push) - FIFO_CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/result_sram_reader.sv
// rtl/result_sram_reader.sv - streams a block of result-SRAM words out on a valid/ready port
module result_sram_reader
    import result_reader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    output logic [ADDR_W-1:0] dut__tb__sram_result_read_address,
    input  logic [DATA_W-1:0] tb__dut__sram_result_read_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              done
);

    state_t                state_q;
    state_t                state_d;
    logic [ADDR_W-1:0]     next_addr_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [CNT_W-1:0]      issue_rem_q;
    logic [CNT_W-1:0]      deliver_rem_q;
    logic                  inflight_q;

    logic [FIFO_CNT_W-1:0] fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_W-1:0]     fifo_head;

    logic                  start_fire;
    logic                  pop;
    logic                  issue;
    logic [2:0]            occupancy;

    assign start_fire = start_valid && start_ready;
    assign out_valid  = !fifo_empty;
    assign out_data   = fifo_head;
    assign pop        = out_valid && out_ready;
    assign out_last   = out_valid && (deliver_rem_q == CNT_W'(1));

    // A word leaving this cycle frees its slot, so streaming keeps one word per clock.
    assign occupancy = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);
    assign issue     = (state_q == READ) && (occupancy < 3'd2);

    assign dut__tb__sram_result_read_address = issue ? next_addr_q : addr_q;

    result_reader_fifo #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight_q),
        .push_data (tb__dut__sram_result_read_data),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        state_d     = state_q;
        start_ready = 1'b0;
        done        = 1'b0;
        case (state_q)
            IDLE: begin
                start_ready = !reset;
                if (start_fire) begin
                    state_d = (word_count == '0) ? DONE : READ;
                end
            end
            READ: begin
                if (issue && (issue_rem_q == CNT_W'(1))) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (deliver_rem_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            next_addr_q   <= '0;
            addr_q        <= '0;
            issue_rem_q   <= '0;
            deliver_rem_q <= '0;
            inflight_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= issue;
            if (start_fire) begin
                next_addr_q   <= base_addr;
                issue_rem_q   <= word_count;
                deliver_rem_q <= word_count;
            end
            if (issue) begin
                addr_q      <= next_addr_q;
                next_addr_q <= next_addr_q + ADDR_W'(1);
                issue_rem_q <= issue_rem_q - CNT_W'(1);
            end
            if (pop) begin
                deliver_rem_q <= deliver_rem_q - CNT_W'(1);
            end
        end
    end

    // The issue rule leaves room for every returning word.
    assert property (@(posedge clk) disable iff (reset) !(inflight_q && fifo_full));

endmodule

// File: tb/tb_result_sram_reader.sv
// tb/tb_result_sram_reader.sv - randomized self-checking bench for result_sram_reader
module tb_result_sram_reader;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int CW = 13;

    logic          clk = 1'b0;
    logic          reset;
    logic          start_valid;
    logic          start_ready;
    logic [AW-1:0] base_addr;
    logic [CW-1:0] word_count;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          done;

    logic [DW-1:0] mem [1 << AW];

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] got_data [$];
    bit            got_last [$];
    int            got_k [$];
    logic [AW-1:0] addr_seq [$];
    logic [DW-1:0] exp_q [$];
    int            done_k;
    int            done_cnt;
    int            first_valid_k;
    int            stall_viol;
    int            max_lead;
    int            extra_hs;
    bit            timed_out;

    result_sram_reader dut (
        .clk                               (clk),
        .reset                             (reset),
        .start_valid                       (start_valid),
        .start_ready                       (start_ready),
        .base_addr                         (base_addr),
        .word_count                        (word_count),
        .dut__tb__sram_result_read_address (rd_addr),
        .tb__dut__sram_result_read_data    (rd_data),
        .out_valid                         (out_valid),
        .out_ready                         (out_ready),
        .out_data                          (out_data),
        .out_last                          (out_last),
        .done                              (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rd_data <= mem[rd_addr];

    task automatic build_exp(input logic [AW-1:0] base, input int cnt);
        logic [AW-1:0] a;
        exp_q.delete();
        for (int i = 0; i < cnt; i++) begin
            a = base + AW'(i);
            exp_q.push_back(mem[a]);
        end
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready
    task automatic run_xfer(input logic [AW-1:0] base, input int cnt, input int mode,
                            input bit hold, input int abort_after);
        int            w;
        int            ph;
        int            lead;
        bit            prev_stall;
        logic [DW-1:0] prev_data;
        got_data.delete();
        got_last.delete();
        got_k.delete();
        addr_seq.delete();
        done_k = -1; done_cnt = 0; first_valid_k = -1;
        stall_viol = 0; max_lead = 0; extra_hs = 0; timed_out = 0;
        prev_stall = 0; prev_data = '0;
        w = 0;
        @(negedge clk);
        while (!start_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!start_ready) begin
            timed_out = 1;
            return;
        end
        start_valid = 1'b1;
        base_addr   = base;
        word_count  = CW'(cnt);
        @(posedge clk);
        #1;
        if (!hold) start_valid = 1'b0;
        for (int k = 1; k <= 400; k++) begin
            ph = (k - 1) % 4;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (ph == 0) || (ph == 3);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            if (prev_stall && (!out_valid || out_data !== prev_data)) stall_viol++;
            if (addr_seq.size() == 0 || addr_seq[$] != rd_addr) addr_seq.push_back(rd_addr);
            if (cnt > 0) begin
                lead = addr_seq.size() - 1 - got_data.size();
                if (lead > max_lead) max_lead = lead;
            end
            if (out_valid && first_valid_k < 0) first_valid_k = k;
            if (hold && start_valid && start_ready) extra_hs++;
            if (out_valid && out_ready) begin
                got_data.push_back(out_data);
                got_last.push_back(out_last);
                got_k.push_back(k);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (done) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
            if (abort_after > 0 && got_data.size() >= abort_after) return;
            if (done_k >= 0 && k >= done_k + 2) return;
            @(posedge clk);
            #1;
        end
        timed_out = 1;
    endtask

    task automatic check_stream(input string name, input int cnt);
        int n;
        tests++;
        if (timed_out) begin
            fails++;
            $display("FAIL %s_timeout: block did not finish within the cycle budget", name);
        end
        tests++;
        if (got_data.size() !== cnt) begin
            fails++;
            $display("FAIL %s_count: got %0d words, expected %0d", name, got_data.size(), cnt);
        end
        n = (got_data.size() < cnt) ? got_data.size() : cnt;
        for (int i = 0; i < n; i++) begin
            tests++;
            if (got_data[i] !== exp_q[i] || got_last[i] !== (i == cnt - 1)) begin
                fails++;
                $display("FAIL %s_word[%0d]: got data %h last %0d, expected data %h last %0d",
                         name, i, got_data[i], got_last[i], exp_q[i], (i == cnt - 1));
            end
        end
        tests++;
        if (done_cnt !== 1) begin
            fails++;
            $display("FAIL %s_done_pulses: got %0d, expected 1", name, done_cnt);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start_valid = 1'b0; out_ready = 1'b1;
        base_addr = '0; word_count = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if (start_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_start_ready_during: got %0b, expected 0", start_ready);
        end
        reset = 1'b0;
        #1;
        tests++;
        if ({start_ready, out_valid, out_last, done} !== 4'b1000 || rd_addr !== '0 || out_data !== '0) begin
            fails++;
            $display("FAIL reset_state: got rdy/vld/last/done %b addr %h data %h, expected 1000 000 00000000",
                     {start_ready, out_valid, out_last, done}, rd_addr, out_data);
        end
    endtask

    task automatic test_basic();
        build_exp(12'd5, 4);
        run_xfer(12'd5, 4, 0, 0, 0);
        check_stream("basic", 4);
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (i >= got_data.size() || got_data[i] !== 32'h1005 + 32'(i)) begin
                fails++;
                $display("FAIL basic_const[%0d]: got %h, expected %h", i,
                         (i < got_data.size()) ? got_data[i] : 32'hx, 32'h1005 + 32'(i));
            end
        end
        tests++;
        if (got_k.size() != 4 || got_k[3] - got_k[0] != 3) begin
            fails++;
            $display("FAIL basic_throughput: got %0d words, span %0d, expected 4 words span 3",
                     got_k.size(), (got_k.size() == 4) ? got_k[3] - got_k[0] : -1);
        end
        tests++;
        if (first_valid_k !== 3) begin
            fails++;
            $display("FAIL basic_first_valid: got cycle %0d, expected 3", first_valid_k);
        end
        tests++;
        if (addr_seq.size() != 4 || addr_seq[0] != 12'd5 || addr_seq[3] != 12'd8) begin
            fails++;
            $display("FAIL basic_addr: got %0d addresses first %h, expected 4 addresses 005..008",
                     addr_seq.size(), addr_seq[0]);
        end
        tests++;
        if (got_k.size() == 0 || done_k < got_k[$] + 1 || done_k > got_k[$] + 2) begin
            fails++;
            $display("FAIL basic_done_time: got cycle %0d, expected just after last pop", done_k);
        end
    endtask

    task automatic test_zero_length();
        run_xfer(12'h300, 0, 0, 0, 0);
        tests++;
        if (first_valid_k !== -1 || got_data.size() !== 0) begin
            fails++;
            $display("FAIL zero_valid: got first valid at %0d with %0d words, expected none",
                     first_valid_k, got_data.size());
        end
        tests++;
        if (addr_seq.size() != 1 || addr_seq[0] != 12'd8) begin
            fails++;
            $display("FAIL zero_addr: got %0d addresses first %h, expected held 008",
                     addr_seq.size(), addr_seq[0]);
        end
        tests++;
        if (done_cnt !== 1 || done_k < 1 || done_k > 3) begin
            fails++;
            $display("FAIL zero_done: got %0d pulses at cycle %0d, expected 1 within 3 cycles",
                     done_cnt, done_k);
        end
        tests++;
        if (start_ready !== 1'b1) begin
            fails++;
            $display("FAIL zero_start_ready: got %0b, expected 1", start_ready);
        end
    endtask

    task automatic test_wrap();
        build_exp(12'hFFE, 4);
        run_xfer(12'hFFE, 4, 0, 0, 0);
        check_stream("wrap", 4);
        tests++;
        if (addr_seq.size() != 4 || addr_seq[0] != 12'hFFE || addr_seq[1] != 12'hFFF ||
            addr_seq[2] != 12'h000 || addr_seq[3] != 12'h001) begin
            fails++;
            $display("FAIL wrap_addr: got %0d addresses last %h, expected FFE FFF 000 001",
                     addr_seq.size(), addr_seq[$]);
        end
    endtask

    task automatic test_backpressure();
        build_exp(12'h0A0, 6);
        run_xfer(12'h0A0, 6, 1, 0, 0);
        check_stream("bp", 6);
        tests++;
        if (stall_viol !== 0) begin
            fails++;
            $display("FAIL bp_stable: got %0d unstable stall cycles, expected 0", stall_viol);
        end
        tests++;
        if (max_lead > 2) begin
            fails++;
            $display("FAIL bp_lead: got address lead %0d, expected at most 2", max_lead);
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] base;
        logic [AW-1:0] a;
        int            cnt;
        for (int t = 0; t < 8; t++) begin
            base = AW'($urandom_range(0, 4095));
            cnt  = $urandom_range(1, 12);
            for (int i = 0; i < cnt; i++) begin
                a = base + AW'(i);
                mem[a] = $urandom;
            end
            build_exp(base, cnt);
            run_xfer(base, cnt, 2, 0, 0);
            check_stream("rand", cnt);
            tests++;
            if (stall_viol !== 0 || max_lead > 2) begin
                fails++;
                $display("FAIL rand_flow: got %0d stall errors lead %0d, expected 0 and at most 2",
                         stall_viol, max_lead);
            end
        end
    endtask

    task automatic test_busy_reset();
        build_exp(12'h200, 8);
        run_xfer(12'h200, 8, 0, 1, 3);
        tests++;
        if (extra_hs !== 0 || done_cnt !== 0) begin
            fails++;
            $display("FAIL busy_accept: got %0d extra handshakes %0d done pulses, expected 0 and 0",
                     extra_hs, done_cnt);
        end
        tests++;
        if (got_data.size() < 3 || got_data[0] !== exp_q[0] || got_data[2] !== exp_q[2]) begin
            fails++;
            $display("FAIL busy_data: got %0d words, expected first three of block", got_data.size());
        end
        reset = 1'b1;
        start_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if ({start_ready, out_valid, done} !== 3'b100 || rd_addr !== '0) begin
            fails++;
            $display("FAIL busy_post_reset: got rdy/vld/done %b addr %h, expected 100 000",
                     {start_ready, out_valid, done}, rd_addr);
        end
        build_exp(12'h000, 2);
        run_xfer(12'h000, 2, 0, 0, 0);
        check_stream("after_reset", 2);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h1000 + 32'(i);
        test_reset();
        test_basic();
        test_zero_length();
        test_wrap();
        test_backpressure();
        test_random();
        test_busy_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

endmodule
